// File: rtl/dti_pr_rob_state_table.sv
// rtl/dti_pr_rob_state_table.sv - multi-entry DTI page-request ROB connection-state tracker
module dti_pr_rob_state_table #(
  parameter int                    ENTRY_NUM  = 8,
  parameter int                    TID_WIDTH  = 6,
  parameter int                    TRANS_MAX  = 16,
  parameter int                    DATA_WIDTH = 80,
  parameter int                    KEEP_WIDTH = 10,
  parameter logic [KEEP_WIDTH-1:0] DIS_KEEP   = 10'h00f
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  con_req_valid,
  input  logic [TID_WIDTH-1:0]  con_req_tid,
  output logic                  con_req_ready,
  input  logic                  con_ack,
  input  logic                  con_deny,
  input  logic [TID_WIDTH-1:0]  evt_tid,
  input  logic                  dis_req,
  input  logic                  part_reset,
  input  logic                  trans_req,
  input  logic [TID_WIDTH-1:0]  trans_tid,
  input  logic                  trans_last,
  input  logic                  trans_ack,
  input  logic [TID_WIDTH-1:0]  ack_tid,
  input  logic                  dis_ack,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [DATA_WIDTH-1:0] req_data,
  output logic [KEEP_WIDTH-1:0] req_keep,
  output logic                  req_last,
  output logic [TID_WIDTH-1:0]  req_tid,
  output logic [ENTRY_NUM-1:0]  idle_vec,
  output logic                  dis_done,
  output logic [TID_WIDTH-1:0]  dis_done_tid,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  err_dup
);

  localparam int CNT_W = $clog2(TRANS_MAX + 1);
  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  localparam logic [2:0] S_IDLE          = 3'd0;
  localparam logic [2:0] S_REQ_CON       = 3'd1;
  localparam logic [2:0] S_BYPASS        = 3'd2;
  localparam logic [2:0] S_NORMAL_DIS    = 3'd3;
  localparam logic [2:0] S_PARTIAL_RESET = 3'd4;
  localparam logic [2:0] S_REQ_DIS       = 3'd5;

  logic [2:0]           state_q [ENTRY_NUM];
  logic [2:0]           state_d [ENTRY_NUM];
  logic [TID_WIDTH-1:0] tid_q   [ENTRY_NUM];
  logic [TID_WIDTH-1:0] tid_d   [ENTRY_NUM];
  logic [CNT_W-1:0]     cnt_q   [ENTRY_NUM];
  logic [CNT_W-1:0]     cnt_d   [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] tf_q, tf_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;

  logic                 ovf_q, ovf_d, unf_q, unf_d, dup_q, dup_d;
  logic                 done_q, done_d;
  logic [TID_WIDTH-1:0] done_tid_q, done_tid_d;

  logic [ENTRY_NUM-1:0] idle_w, evt_hit, trans_hit, ack_hit, dup_hit;
  logic [ENTRY_NUM-1:0] req_vec, flush_vec, done_cand, inc_vec, dec_vec;
  logic [ENTRY_NUM-1:0] at_max, at_zero, alloc_sel, done_sel, gnt_vec;
  logic                 dup_any, alloc_fire, found_alloc, found_done, found_gnt;
  logic [PTR_W-1:0]     grant_idx, scan_idx;
  logic [PTR_W:0]       scan_sum, ptr_nxt;

  // Per-entry decode of TID matches, requests and counter boundaries
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      idle_w[i]    = (state_q[i] == S_IDLE);
      evt_hit[i]   = !idle_w[i] && (tid_q[i] == evt_tid);
      trans_hit[i] = !idle_w[i] && (tid_q[i] == trans_tid);
      ack_hit[i]   = !idle_w[i] && (tid_q[i] == ack_tid);
      dup_hit[i]   = !idle_w[i] && (tid_q[i] == con_req_tid);
      at_max[i]    = (cnt_q[i] == CNT_W'(TRANS_MAX));
      at_zero[i]   = (cnt_q[i] == '0);
      flush_vec[i] = (state_q[i] == S_PARTIAL_RESET) && !tf_q[i];
      req_vec[i]   = (state_q[i] == S_PARTIAL_RESET) && (!tf_q[i] || at_zero[i]);
      done_cand[i] = (state_q[i] == S_NORMAL_DIS) && at_zero[i];
      inc_vec[i]   = trans_req && trans_hit[i];
      dec_vec[i]   = trans_ack && ack_hit[i];
    end
  end

  assign dup_any    = |dup_hit;
  assign alloc_fire = con_req_valid && con_req_ready && !dup_any;

  // Lowest-index pick for allocation and for disconnect completion
  always_comb begin
    alloc_sel   = '0;
    done_sel    = '0;
    found_alloc = 1'b0;
    found_done  = 1'b0;
    done_tid_d  = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!found_alloc && idle_w[i]) begin
        alloc_sel[i] = 1'b1;
        found_alloc  = 1'b1;
      end
      if (!found_done && done_cand[i]) begin
        done_sel[i] = 1'b1;
        found_done  = 1'b1;
        done_tid_d  = tid_q[i];
      end
    end
  end

  // Round-robin grant starting at the pointer, built only from registered state
  always_comb begin
    gnt_vec   = '0;
    grant_idx = '0;
    found_gnt = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(ENTRY_NUM)) begin
        scan_sum = scan_sum - (PTR_W+1)'(ENTRY_NUM);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!found_gnt && req_vec[scan_idx]) begin
        found_gnt         = 1'b1;
        grant_idx         = scan_idx;
        gnt_vec[scan_idx] = 1'b1;
      end
    end
  end

  // Pointer moves past the granted entry only when the beat is taken
  always_comb begin
    ptr_d   = ptr_q;
    ptr_nxt = {1'b0, grant_idx} + (PTR_W+1)'(1);
    if (found_gnt && req_ready) begin
      ptr_d = (ptr_nxt >= (PTR_W+1)'(ENTRY_NUM)) ? '0 : ptr_nxt[PTR_W-1:0];
    end
  end

  // Next-state for every entry FSM, its counter and trans_finish flag
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      state_d[i] = state_q[i];
      tid_d[i]   = tid_q[i];
      cnt_d[i]   = cnt_q[i];
      tf_d[i]    = tf_q[i];
      if (inc_vec[i] && !dec_vec[i] && !at_max[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i] && !at_zero[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (inc_vec[i]) begin
        tf_d[i] = trans_last;
      end
      case (state_q[i])
        S_IDLE: begin
          if (alloc_fire && alloc_sel[i]) begin
            state_d[i] = S_REQ_CON;
            tid_d[i]   = con_req_tid;
            cnt_d[i]   = '0;
            tf_d[i]    = 1'b0;
          end
        end
        S_REQ_CON: begin
          if (evt_hit[i] && con_deny)     state_d[i] = S_IDLE;
          else if (evt_hit[i] && con_ack) state_d[i] = S_BYPASS;
        end
        S_BYPASS: begin
          if (evt_hit[i] && part_reset)   state_d[i] = S_PARTIAL_RESET;
          else if (evt_hit[i] && dis_req) state_d[i] = S_NORMAL_DIS;
        end
        S_NORMAL_DIS: begin
          if (done_sel[i]) state_d[i] = S_IDLE;
        end
        S_PARTIAL_RESET: begin
          // Acceptance overrides a same-cycle trans_last update
          if (gnt_vec[i] && req_ready) begin
            if (flush_vec[i]) tf_d[i]    = 1'b1;
            else              state_d[i] = S_REQ_DIS;
          end
        end
        S_REQ_DIS: begin
          if (dis_ack && ack_hit[i]) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
    ovf_d  = |(inc_vec & ~dec_vec & at_max);
    unf_d  = |(dec_vec & ~inc_vec & at_zero);
    dup_d  = con_req_valid && con_req_ready && dup_any;
    done_d = found_done;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        state_q[i] <= S_IDLE;
        tid_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      tf_q       <= '0;
      ptr_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dup_q      <= 1'b0;
      done_q     <= 1'b0;
      done_tid_q <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        state_q[i] <= state_d[i];
        tid_q[i]   <= tid_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      tf_q       <= tf_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      dup_q      <= dup_d;
      done_q     <= done_d;
      done_tid_q <= done_tid_d;
    end
  end

  assign idle_vec      = idle_w;
  assign con_req_ready = |idle_w;
  assign req_valid     = found_gnt;
  assign req_data      = '0;
  assign req_last      = found_gnt;
  assign req_keep      = !found_gnt ? '0 : (flush_vec[grant_idx] ? '1 : DIS_KEEP);
  assign req_tid       = found_gnt ? tid_q[grant_idx] : '0;
  assign dis_done      = done_q;
  assign dis_done_tid  = done_tid_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign err_dup       = dup_q;

endmodule

// File: tb/tb_dti_pr_rob_state_table.sv
// tb/tb_dti_pr_rob_state_table.sv - directed self-checking bench for dti_pr_rob_state_table
module tb_dti_pr_rob_state_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        con_req_valid;
  logic [5:0]  con_req_tid;
  logic        con_req_ready;
  logic        con_ack, con_deny;
  logic [5:0]  evt_tid;
  logic        dis_req, part_reset;
  logic        trans_req;
  logic [5:0]  trans_tid;
  logic        trans_last;
  logic        trans_ack;
  logic [5:0]  ack_tid;
  logic        dis_ack;
  logic        req_valid, req_ready;
  logic [79:0] req_data;
  logic [9:0]  req_keep;
  logic        req_last;
  logic [5:0]  req_tid;
  logic [7:0]  idle_vec;
  logic        dis_done;
  logic [5:0]  dis_done_tid;
  logic        err_overflow, err_underflow, err_dup;

  int checks = 0;
  int errors = 0;
  int ovf_pulses;

  logic [5:0] exp_tid  [4] = '{6'd31, 6'd32, 6'd36, 6'd31};
  logic [9:0] exp_keep [4] = '{10'h3ff, 10'h3ff, 10'h3ff, 10'h00f};
  logic [5:0] arb_tids [3] = '{6'd31, 6'd32, 6'd36};

  dti_pr_rob_state_table dut (
    .clk(clk), .rst(rst),
    .con_req_valid(con_req_valid), .con_req_tid(con_req_tid), .con_req_ready(con_req_ready),
    .con_ack(con_ack), .con_deny(con_deny), .evt_tid(evt_tid),
    .dis_req(dis_req), .part_reset(part_reset),
    .trans_req(trans_req), .trans_tid(trans_tid), .trans_last(trans_last),
    .trans_ack(trans_ack), .ack_tid(ack_tid), .dis_ack(dis_ack),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_keep(req_keep), .req_last(req_last), .req_tid(req_tid),
    .idle_vec(idle_vec), .dis_done(dis_done), .dis_done_tid(dis_done_tid),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_dup(err_dup)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    con_req_valid = 1'b0; con_req_tid = '0;
    con_ack = 1'b0; con_deny = 1'b0; evt_tid = '0;
    dis_req = 1'b0; part_reset = 1'b0;
    trans_req = 1'b0; trans_tid = '0; trans_last = 1'b0;
    trans_ack = 1'b0; ack_tid = '0; dis_ack = 1'b0;
    req_ready = 1'b0;
  endtask

  task automatic do_con_req(input logic [5:0] t);
    con_req_valid = 1'b1; con_req_tid = t; step(); con_req_valid = 1'b0;
  endtask

  task automatic do_evt(input logic [5:0] t, input logic a, input logic d, input logic dr, input logic pr);
    evt_tid = t; con_ack = a; con_deny = d; dis_req = dr; part_reset = pr;
    step();
    con_ack = 1'b0; con_deny = 1'b0; dis_req = 1'b0; part_reset = 1'b0;
  endtask

  task automatic do_ack(input logic [5:0] t);
    trans_ack = 1'b1; ack_tid = t; step(); trans_ack = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step(); step();
    check("rst_idle_vec", idle_vec, 8'hff);
    check("rst_con_ready", con_req_ready, 1'b1);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_req_keep", req_keep, 10'h0);
    check("rst_errs", {err_dup, err_overflow, err_underflow, dis_done}, 4'h0);
    rst = 1'b0;
    step();

    // connect and duplicate
    do_con_req(6'd5);
    check("con_alloc_idle", idle_vec, 8'hfe);
    do_evt(6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    do_con_req(6'd5);
    check("dup_err", err_dup, 1'b1);
    check("dup_idle", idle_vec, 8'hfe);
    step();
    check("dup_pulse_end", err_dup, 1'b0);

    // counter bounds on tid 5
    do_ack(6'd5);
    check("underflow", err_underflow, 1'b1);
    ovf_pulses = 0;
    for (int i = 0; i < 17; i++) begin
      trans_req = 1'b1; trans_tid = 6'd5; trans_last = 1'b0;
      step();
      if (err_overflow) ovf_pulses++;
    end
    trans_req = 1'b0;
    step();
    if (err_overflow) ovf_pulses++;
    check("overflow_pulses", ovf_pulses, 1);
    trans_req = 1'b1; trans_tid = 6'd5; trans_ack = 1'b1; ack_tid = 6'd5;
    step();
    trans_req = 1'b0; trans_ack = 1'b0;
    check("simul_no_err", {err_overflow, err_underflow}, 2'b00);
    for (int i = 0; i < 14; i++) do_ack(6'd5);

    // normal disconnect with count 2
    do_evt(6'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ndis_busy", idle_vec, 8'hfe);
    check("ndis_no_done0", dis_done, 1'b0);
    do_ack(6'd5);
    check("ndis_no_done1", dis_done, 1'b0);
    do_ack(6'd5);
    check("ndis_no_done2", dis_done, 1'b0);
    step();
    check("ndis_done", dis_done, 1'b1);
    check("ndis_done_tid", dis_done_tid, 6'd5);
    check("ndis_idle", idle_vec, 8'hff);
    step();
    check("ndis_pulse_end", dis_done, 1'b0);

    // fill all entries, deny entry 3, refill
    for (int i = 0; i < 8; i++) do_con_req(6'(10 + i));
    check("fill_ready", con_req_ready, 1'b0);
    check("fill_idle", idle_vec, 8'h00);
    do_evt(6'd13, 1'b0, 1'b1, 1'b0, 1'b0);
    check("deny_idle", idle_vec, 8'h08);
    check("deny_ready", con_req_ready, 1'b1);
    do_con_req(6'd20);
    check("refill_idle", idle_vec, 8'h00);
    do_evt(6'd20, 1'b0, 1'b1, 1'b0, 1'b0);
    check("refill_entry3", idle_vec, 8'h08);

    // reset while entries are active
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_idle", idle_vec, 8'hff);
    check("midrst_ready", con_req_ready, 1'b1);

    // partial reset with open transactions
    do_con_req(6'd7);
    do_evt(6'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      trans_req = 1'b1; trans_tid = 6'd7; trans_last = 1'b0; step();
    end
    trans_req = 1'b0;
    do_evt(6'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    check("flush_valid", req_valid, 1'b1);
    check("flush_keep", req_keep, 10'h3ff);
    check("flush_last", req_last, 1'b1);
    check("flush_data", req_data, 80'h0);
    check("flush_tid", req_tid, 6'd7);
    for (int i = 0; i < 4; i++) begin
      step();
      check("flush_hold", {req_valid, req_keep, req_tid}, {1'b1, 10'h3ff, 6'd7});
    end
    req_ready = 1'b1; step(); req_ready = 1'b0;
    check("flush_taken", req_valid, 1'b0);
    do_ack(6'd7);
    do_ack(6'd7);
    check("dis_wait_cnt", req_valid, 1'b0);
    do_ack(6'd7);
    check("disbeat", {req_valid, req_keep, req_tid}, {1'b1, 10'h00f, 6'd7});
    req_ready = 1'b1; step(); req_ready = 1'b0;
    check("disbeat_taken", req_valid, 1'b0);
    check("req_dis_busy", idle_vec, 8'hfe);
    dis_ack = 1'b1; ack_tid = 6'd7; step(); dis_ack = 1'b0;
    check("dis_ack_idle", idle_vec, 8'hff);

    // arbitration across entries 1, 2, 6 (pointer sits at 1)
    for (int i = 0; i < 7; i++) do_con_req(6'(30 + i));
    for (int i = 0; i < 3; i++) do_evt(arb_tids[i], 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_evt(arb_tids[i], 1'b0, 1'b0, 1'b0, 1'b1);
    check("arb_first_tid", req_tid, 6'd31);
    req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("arb_beat", {req_valid, req_tid, req_keep}, {1'b1, exp_tid[k], exp_keep[k]});
      step();
    end
    req_ready = 1'b0;
    check("arb_pending", {req_valid, req_tid, req_keep}, {1'b1, 6'd32, 10'h00f});

    // reset drops the in-flight beat
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_drop_valid", req_valid, 1'b0);
    check("rst_drop_idle", idle_vec, 8'hff);
    do_ack(6'd32);
    step();
    check("unmatched_ack", err_underflow, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dti_pr_rob_state_table.md
Name: dti_pr_rob_state_table

Overview:
- Multi-entry connection-state tracker for the DTI page-request ROB; next generation of the single-entry ROB state tracker.
- Holds ENTRY_NUM independent per-TBU connection FSMs, each with an outstanding-transaction counter, selected by TID lookup.
- Arbitrates the flush and disconnect beats of all entries onto one custom request channel toward the DTI link.
- Adds saturating counters with error flags, duplicate-TID detection and a completion strobe for normal disconnects.

Parameters:
ENTRY_NUM, 8, number of connection entries (power of 2 not required, >=2)
TID_WIDTH, 6, TBU id width
TRANS_MAX, 16, max outstanding transactions per entry
DATA_WIDTH, 80, request data width
KEEP_WIDTH, 10, request keep width (DATA_WIDTH/8)
DIS_KEEP, 10'h00f, keep value for a disconnect beat

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
con_req_valid  in  1  connect request
con_req_tid  in  TID_WIDTH  TID to connect
con_req_ready  out  1  a free entry exists
con_ack  in  1  connect accepted, qualified by evt_tid
con_deny  in  1  connect denied, qualified by evt_tid
evt_tid  in  TID_WIDTH  TID for con_ack/con_deny/dis_req/part_reset
dis_req  in  1  normal disconnect request
part_reset  in  1  partial-reset request
trans_req  in  1  transaction issued
trans_tid  in  TID_WIDTH  TID of trans_req
trans_last  in  1  trans_req is the last beat of its transaction
trans_ack  in  1  transaction completed
ack_tid  in  TID_WIDTH  TID of trans_ack
dis_ack  in  1  link disconnect acknowledge, qualified by ack_tid
req_valid  out  1  request beat valid
req_ready  in  1  request beat accepted
req_data  out  DATA_WIDTH  always 0
req_keep  out  KEEP_WIDTH  beat keep
req_last  out  1  always 1 when req_valid
req_tid  out  TID_WIDTH  TID of the beat
idle_vec  out  ENTRY_NUM  per-entry idle
dis_done  out  1  one-cycle pulse: normal disconnect completed
dis_done_tid  out  TID_WIDTH  TID for dis_done
err_overflow  out  1  pulse: trans_req at count TRANS_MAX
err_underflow  out  1  pulse: trans_ack at count 0
err_dup  out  1  pulse: con_req for a TID that is already active

Behaviour:
- Reset: all entries go to IDLE, counters 0 and trans_finish 0. idle_vec all ones, arbiter pointer 0, and all outputs 0 except con_req_ready=1.
- Per-entry FSM states: IDLE, REQ_CON, BYPASS, NORMAL_DIS, PARTIAL_RESET, REQ_DIS. An entry matches an event when it is non-IDLE and its stored TID equals the event TID.
- Allocation: con_req_valid&&con_req_ready loads the lowest-index IDLE entry with con_req_tid and moves it to REQ_CON, effective next cycle.
  - A TID already held by a non-IDLE entry is dropped and err_dup pulses.
  - con_req_ready = |idle_vec.
- REQ_CON: con_ack -> BYPASS; con_deny -> IDLE. If both are set, con_deny wins.
- BYPASS: part_reset -> PARTIAL_RESET; dis_req -> NORMAL_DIS. If both are set, part_reset wins.
- NORMAL_DIS: when count==0 -> IDLE. dis_done pulses with that TID in the same cycle as the transition. Lowest index wins if several complete in one cycle; the others wait one cycle.
- PARTIAL_RESET:
  - If trans_finish==0, the entry requests a FLUSH beat (keep all ones). Acceptance sets trans_finish=1.
  - If trans_finish==1 and count==0, the entry requests a DISCONNECT beat (keep=DIS_KEEP). Acceptance -> REQ_DIS.
- REQ_DIS: dis_ack with matching ack_tid -> IDLE.
- Events addressed to an entry in a state that does not use them are ignored, with no error.
- Counter: width $clog2(TRANS_MAX+1). trans_req to a matching entry increments the count and ack decrements it.
  - req and ack to the same entry in the same cycle: count holds.
  - Increment at TRANS_MAX: count holds and err_overflow pulses. Decrement at 0: count holds and err_underflow pulses.
  - trans_finish <= trans_last on every matching trans_req.
  - Unmatched TIDs are ignored.
- Output arbitration: round-robin over requesting entries. The grant is combinational from registered state.
  - The pointer advances to grant+1 (mod ENTRY_NUM) only on req_valid&&req_ready.
  - While req_ready=0, req_valid/keep/tid hold stable: the granted entry's request persists because its state cannot change without acceptance.
- Errors and dis_done are registered one-cycle pulses, asserted the cycle after the causing event.
- rst asserted mid-operation: all state clears on the next edge and any in-flight beat is dropped.

Test Plan:
- Connect: con_req tid 5 then con_ack tid 5 -> idle_vec[0]=0, entry 0 in BYPASS. A second con_req tid 5 -> err_dup=1 and idle_vec unchanged.
- Fill: ENTRY_NUM con_reqs with distinct TIDs -> con_req_ready=0. A con_deny on tid of entry 3 -> idle_vec[3]=1, con_req_ready=1, and the next con_req lands in entry 3.
- Partial reset, open transaction: 3 trans_req (last=0) then part_reset.
  - A FLUSH beat appears with keep 10'h3ff, last 1 and data 0, and holds under req_ready=0 for 4 cycles.
  - After acceptance and 3 trans_ack, a DISCONNECT beat appears with keep 10'h00f.
  - After dis_ack the entry is IDLE.
- Arbitration: entries 1, 2 and 6 all request with req_ready=1 -> beats issue in TID order of entries 1, 2, 6, and the pointer wraps to 1 afterwards.
- Counter bounds: 17 trans_req with TRANS_MAX=16 -> count 16 and one err_overflow pulse. trans_ack at 0 -> err_underflow. Simultaneous req+ack -> count unchanged.
- Normal disconnect with count 2: dis_req -> NORMAL_DIS. After 2 trans_ack, dis_done pulses with the correct TID and the entry returns to IDLE. Asserting rst mid-flow clears everything next cycle.
